vh_stim_misr: RTL and testbench

- Self-checking stimulus driver and response compactor for combinational expression blocks with packed `a`/`b` inputs and a packed `y` output.
- Generates pseudo-random `a`/`b` vectors from a 64-bit xorshift generator and drives them to the device under test (DUT).
- Waits a fixed settle time, then folds the DUT's `y` into a 32-bit signature register (MISR).
- Sits at the opposite end of the DUT's port list: it drives what the DUT reads and reads what the DUT drives.

---
 rtl/vh_stim_misr.sv | 166 ++++++++++++++++
 tb/tb_vh_stim_misr.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vh_stim_misr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : vh_stim_misr                                                     |
// | Purpose  : Stimulus driver and response compactor for a combinational       |
// |            a/b -> y block. It drives xorshift64 vectors to the block, waits |
// |            a settle time, then folds y into a 32-bit MISR signature.        |
// | Option   : VH_CORNER_VECTORS_EN prepends four fixed corner vectors per run. |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module vh_stim_misr #(
  parameter int          WIDTH       = 27,
  parameter int          NUM_VECTORS = 256,
  parameter int          SETTLE_CYC  = 1,
  parameter logic [63:0] GEN_SEED    = 64'h1,
  parameter logic [31:0] SIG_SEED    = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] y_in,
  output logic [31:0]      signature,
  output logic [15:0]      vec_count
);

  localparam logic [31:0] POLY = 32'h04C11DB7;
`ifdef VH_CORNER_VECTORS_EN
  localparam int RUN_LEN = NUM_VECTORS + 4;
`else
  localparam int RUN_LEN = NUM_VECTORS;
`endif
  localparam logic [15:0] RUN_LEN_C   = 16'(RUN_LEN);
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] gen;
  logic [3:0]  settle_cnt;
  logic [15:0] vec_count_nxt;

  // One xorshift64 step; each line uses the result of the previous one.
  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  assign vec_count_nxt = vec_count + 16'd1;

`ifdef VH_CORNER_VECTORS_EN
  logic [2:0]       corner_idx;
  logic             corner_active;
  logic [WIDTH-1:0] corner_a;
  logic [WIDTH-1:0] corner_b;

  assign corner_active = (corner_idx < 3'd4);

  // Fixed corner patterns: 0/0, 1s/1s, 1s/0, 0/1s.
  always_comb begin
    corner_a = '0;
    corner_b = '0;
    case (corner_idx)
      3'd1: begin
        corner_a = '1;
        corner_b = '1;
      end
      3'd2: corner_a = '1;
      3'd3: corner_b = '1;
      default: ;
    endcase
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; run ends when the capture that just happened completes the run.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_DRIVE;
      ST_DRIVE:   state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == 4'd0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = (vec_count_nxt == RUN_LEN_C) ? ST_DONE : ST_DRIVE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: generator, vector outputs, settle counter, MISR and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
      gen        <= GEN_SEED;
      signature  <= SIG_SEED;
      vec_count  <= 16'd0;
      settle_cnt <= 4'd0;
`ifdef VH_CORNER_VECTORS_EN
      corner_idx <= 3'd0;
`endif
    end else begin
      // busy trails the state by one cycle so it covers exactly the cycles before done.
      busy <= (state != ST_IDLE) && (state != ST_DONE);
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            gen       <= GEN_SEED;
            signature <= SIG_SEED;
            vec_count <= 16'd0;
`ifdef VH_CORNER_VECTORS_EN
            corner_idx <= 3'd0;
`endif
          end
        end
        ST_DRIVE: begin
`ifdef VH_CORNER_VECTORS_EN
          if (corner_active) begin
            a_out      <= corner_a;
            b_out      <= corner_b;
            corner_idx <= corner_idx + 3'd1;
          end else begin
            a_out <= gen[WIDTH-1:0];
            b_out <= gen[WIDTH +: WIDTH];
            gen   <= xorshift64(gen);
          end
`else
          a_out <= gen[WIDTH-1:0];
          b_out <= gen[WIDTH +: WIDTH];
          gen   <= xorshift64(gen);
`endif
          settle_cnt <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        ST_CAPTURE: begin
          signature <= {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ 32'(y_in);
          vec_count <= vec_count_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vh_stim_misr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_vh_stim_misr                                                  |
// | Purpose  : Bench for vh_stim_misr with a behavioural model of the vector    |
// |            stream and signature; the bench also plays the target block.     |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_vh_stim_misr;

  localparam int          W   = 27;
  localparam int          NV  = 4;
  localparam int          SC  = 1;
  localparam logic [63:0] GS  = 64'h1;
  localparam logic [31:0] SS  = 32'h0;
  localparam int          P   = 2 + SC;
`ifdef VH_CORNER_VECTORS_EN
  localparam int TOTAL = NV + 4;
`else
  localparam int TOTAL = NV;
`endif
  localparam int T = TOTAL * P;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy, done;
  logic [W-1:0] a_out, b_out, y_in;
  logic [31:0]  signature;
  logic [15:0]  vec_count;

  int           checks = 0;
  int           errors = 0;
  int           mode = 0;
  logic [W-1:0] mask = '0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  vh_stim_misr #(
    .WIDTH(W), .NUM_VECTORS(NV), .SETTLE_CYC(SC), .GEN_SEED(GS), .SIG_SEED(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .y_in(y_in), .signature(signature), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // The combinational block under test: zero, constant one, or a masked sum.
  assign y_in = (mode == 0) ? '0 : (mode == 1) ? W'(1) : ((a_out ^ mask) + b_out);

  function automatic logic [W-1:0] y_of(input logic [W-1:0] a, input logic [W-1:0] b);
    if (mode == 0) return '0;
    if (mode == 1) return W'(1);
    return (a ^ mask) + b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected vector stream of one run, straight from the generator rules.
  task automatic build_model();
    longint unsigned x;
    x = GS;
    exp_a.delete();
    exp_b.delete();
`ifdef VH_CORNER_VECTORS_EN
    exp_a.push_back('0); exp_b.push_back('0);
    exp_a.push_back('1); exp_b.push_back('1);
    exp_a.push_back('1); exp_b.push_back('0);
    exp_a.push_back('0); exp_b.push_back('1);
`endif
    for (int i = 0; i < NV; i++) begin
      exp_a.push_back(W'(x));
      exp_b.push_back(W'(x >> W));
      x = x ^ (x << 13);
      x = x ^ (x >> 7);
      x = x ^ (x << 17);
    end
  endtask

  // Signature as polynomial division remainder accumulation over the responses.
  function automatic logic [31:0] model_sig();
    logic [31:0] s;
    s = SS;
    for (int i = 0; i < TOTAL; i++) begin
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ 32'(y_of(exp_a[i], exp_b[i]));
    end
    return s;
  endfunction

  // One full run; chained means start is already high from the previous run.
  task automatic run(input bit chained, input bit hold_after, input bit poke_busy);
    logic [31:0] es;
    int          ev;
    es = model_sig();
    if (!chained) start = 1'b1;
    @(posedge clk); #1;
    start = hold_after;
    for (int cyc = 1; cyc <= T + 1; cyc++) begin
      @(posedge clk); #1;
      if (poke_busy && cyc == 4) start = 1'b1;
      if (poke_busy && cyc == 5) start = 1'b0;
      ev = cyc / P;
      if (ev > TOTAL) ev = TOTAL;
      chk("busy", 64'(busy), 64'(cyc <= T));
      chk("done", 64'(done), 64'(cyc == T + 1));
      chk("vec_count", 64'(vec_count), 64'(ev));
      if ((cyc % P) == 1 && (cyc / P) < TOTAL) begin
        chk("a_out", 64'(a_out), 64'(exp_a[cyc / P]));
        chk("b_out", 64'(b_out), 64'(exp_b[cyc / P]));
      end
    end
    chk("signature", 64'(signature), 64'(es));
    chk("a_hold", 64'(a_out), 64'(exp_a[TOTAL-1]));
    chk("b_hold", 64'(b_out), 64'(exp_b[TOTAL-1]));
  endtask

  initial begin
    build_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_a", 64'(a_out), 64'd0);
    chk("rst_b", 64'(b_out), 64'd0);
    chk("rst_sig", 64'(signature), 64'(SS));
    chk("rst_cnt", 64'(vec_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    mode = 1;
    run(1'b0, 1'b0, 1'b0);

    mode = 0;
    run(1'b0, 1'b0, 1'b1);

    mode = 2;
    mask = W'($urandom);
    run(1'b0, 1'b1, 1'b0);
    mask = W'($urandom);
    run(1'b1, 1'b0, 1'b0);

    // Reset while in SETTLE, then confirm nothing resumes.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_a", 64'(a_out), 64'd0);
    chk("mid_rst_b", 64'(b_out), 64'd0);
    chk("mid_rst_sig", 64'(signature), 64'(SS));
    chk("mid_rst_cnt", 64'(vec_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * T; i++) begin
      @(posedge clk); #1;
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end

    mode = 2;
    mask = W'($urandom);
    run(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
